metadata_output_fifo: RTL and testbench

Output buffer that sits directly downstream of the metadata packager. It captures each single-cycle `metadata_valid` pulse carrying an `eth_metadata_t` record into a small FIFO, then presents the records to the consumer (classifier/forwarding logic) over a valid/ready handshake. The packager cannot be back-pressured, so on overflow this block drops the incoming record and accounts for it.

---
 rtl/metadata_output_fifo_if.sv | 33 +++
 rtl/metadata_output_fifo.sv | 73 +++++++
 tb/tb_metadata_output_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/metadata_output_fifo_if.sv
// Metadata record type and the packager/consumer bus around metadata_output_fifo.
// The FIFO side takes the slave modport; the environment drives the master modport.
package eth_metadata_pkg;
    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [11:0] vlan_id;
        logic [15:0] ethertype;
        logic        has_vlan;
        logic        is_ipv4;
        logic        is_ipv6;
    } eth_metadata_t;
endpackage

interface metadata_output_fifo_if;
    import eth_metadata_pkg::*;

    eth_metadata_t metadata;
    logic          metadata_valid;
    eth_metadata_t m_metadata;
    logic          m_valid;
    logic          m_ready;

    modport slave (
        input  metadata, metadata_valid, m_ready,
        output m_metadata, m_valid
    );

    modport master (
        output metadata, metadata_valid, m_ready,
        input  m_metadata, m_valid
    );
endinterface

// File: rtl/metadata_output_fifo.sv
// Drop-on-full FWFT buffer between the metadata packager and its consumer.
// Define METADATA_FIFO_DROP_STATS_EN to build the drop_count/overflow statistics.
module metadata_output_fifo
    import eth_metadata_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    metadata_output_fifo_if.slave    bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic [15:0]              drop_count,
    output logic                     overflow,
    input  logic                     drop_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    eth_metadata_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, drop;

    assign bus.m_valid = (count != '0);
    assign fifo_full   = (count == CW'(DEPTH));
    assign fifo_count  = count;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign pop  = bus.m_valid && bus.m_ready;
    assign push = bus.metadata_valid && (!fifo_full || pop);
    assign drop = bus.metadata_valid && fifo_full && !pop;

    assign bus.m_metadata = bus.m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; empty-forcing on m_metadata hides stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.metadata;
    end

`ifdef METADATA_FIFO_DROP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop_clr) begin
            drop_count <= drop ? 16'd1 : 16'd0;
            overflow   <= drop;
        end else if (drop) begin
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            overflow <= 1'b1;
        end
    end
`else
    logic unused_drop_stats;
    assign unused_drop_stats = drop_clr ^ drop;
    assign drop_count = 16'h0;
    assign overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_metadata_output_fifo.sv
// Directed bench for metadata_output_fifo (DEPTH=4): vector table plus corner-case sequences.
module tb_metadata_output_fifo;
    import eth_metadata_pkg::*;

`ifdef METADATA_FIFO_DROP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] fifo_count;
    logic       fifo_full;
    logic [15:0] drop_count;
    logic       overflow;
    logic       drop_clr;
    int         errors = 0;
    int         checks = 0;

    metadata_output_fifo_if bus ();

    metadata_output_fifo #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .drop_count (drop_count),
        .overflow   (overflow),
        .drop_clr   (drop_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [11:0] vid;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [11:0] e_vid;
        logic [2:0]  e_count;
        logic        e_full;
        logic [15:0] e_drops;
    } vec_t;

    function automatic eth_metadata_t mk(input logic [11:0] vid);
        eth_metadata_t m;
        m.dest_mac  = 48'hA000_0000_0000 | 48'(vid);
        m.src_mac   = {vid, 36'h0_0000_0005};
        m.vlan_id   = vid;
        m.ethertype = 16'h0800 + 16'(vid);
        m.has_vlan  = 1'b1;
        m.is_ipv4   = vid[0];
        m.is_ipv6   = ~vid[0];
        return m;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    eth_metadata_t got[$];
    eth_metadata_t held;
    logic seen;
    logic [15:0] d;

    initial begin
        rst_n = 1'b0;
        drop_clr = 1'b0;
        bus.metadata = '0;
        bus.metadata_valid = 1'b0;
        bus.m_ready = 1'b0;
        #12;
        chk("reset_valid", 192'(bus.m_valid), 0);
        chk("reset_data", 192'(bus.m_metadata), 0);
        chk("reset_count", 192'(fifo_count), 0);
        chk("reset_full", 192'(fifo_full), 0);
        chk("reset_drops", 192'(drop_count), 0);
        chk("reset_ovf", 192'(overflow), 0);
        step();
        rst_n = 1'b1;
        step();

        // single pulse with m_ready high
        begin
            eth_metadata_t m;
            m = '0;
            m.dest_mac = 48'h0011_2233_4455;
            m.is_ipv4  = 1'b1;
            bus.m_ready = 1'b1;
            bus.metadata = m;
            bus.metadata_valid = 1'b1;
            chk("single_pre_valid", 192'(bus.m_valid), 0);
            step();
            bus.metadata_valid = 1'b0;
            chk("single_valid", 192'(bus.m_valid), 1);
            chk("single_data", 192'(bus.m_metadata), 192'(m));
            step();
            chk("single_valid_after", 192'(bus.m_valid), 0);
            chk("single_data_after", 192'(bus.m_metadata), 0);
            chk("single_count_after", 192'(fifo_count), 0);
        end

        // v vid rdy clr | valid vid count full drops
        d = STATS ? 16'd1 : 16'd0;
        vecs = '{
            '{1, 1, 0, 0, 1, 1, 1, 0, 0},
            '{1, 2, 0, 0, 1, 1, 2, 0, 0},
            '{1, 3, 0, 0, 1, 1, 3, 0, 0},
            '{1, 4, 0, 0, 1, 1, 4, 1, 0},
            '{1, 5, 0, 0, 1, 1, 4, 1, d},
            '{1, 6, 0, 0, 1, 1, 4, 1, 2*d},
            '{1, 9, 1, 0, 1, 2, 4, 1, 2*d},
            '{0, 0, 1, 0, 1, 3, 3, 0, 2*d},
            '{0, 0, 1, 0, 1, 4, 2, 0, 2*d},
            '{0, 0, 1, 0, 1, 9, 1, 0, 2*d},
            '{0, 0, 1, 0, 0, 0, 0, 0, 2*d},
            '{1, 7, 1, 0, 1, 7, 1, 0, 2*d},
            '{0, 0, 1, 1, 0, 0, 0, 0, 0}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            bus.metadata_valid = vecs[i].v;
            bus.metadata = mk(vecs[i].vid);
            bus.m_ready = vecs[i].rdy;
            drop_clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_valid", i), 192'(bus.m_valid), 192'(vecs[i].e_valid));
            chk($sformatf("vec%0d_data", i), 192'(bus.m_metadata),
                vecs[i].e_valid ? 192'(mk(vecs[i].e_vid)) : 192'(0));
            chk($sformatf("vec%0d_count", i), 192'(fifo_count), 192'(vecs[i].e_count));
            chk($sformatf("vec%0d_full", i), 192'(fifo_full), 192'(vecs[i].e_full));
            chk($sformatf("vec%0d_drops", i), 192'(drop_count), 192'(vecs[i].e_drops));
            chk($sformatf("vec%0d_ovf", i), 192'(overflow),
                192'(STATS && vecs[i].e_drops != 0));
        end
        bus.metadata_valid = 1'b0;
        drop_clr = 1'b0;
        bus.m_ready = 1'b0;

        // stall with two entries queued, then random ready drain
        for (int i = 1; i <= 2; i++) begin
            bus.metadata = mk(12'(i));
            bus.metadata_valid = 1'b1;
            step();
        end
        bus.metadata_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("stall%0d", i), 192'(bus.m_metadata), 192'(mk(1)));
        end
        for (int i = 0; i < 200 && fifo_count != 0; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_metadata);
            step();
        end
        bus.m_ready = 1'b0;
        chk("drain_n", 192'(got.size()), 2);
        if (got.size() == 2) begin
            chk("drain_0", 192'(got[0]), 192'(mk(1)));
            chk("drain_1", 192'(got[1]), 192'(mk(2)));
        end

        // mid-stream reset flushes everything
        for (int i = 1; i <= 3; i++) begin
            bus.metadata = mk(12'(20 + i));
            bus.metadata_valid = 1'b1;
            step();
        end
        bus.metadata_valid = 1'b0;
        chk("prerst_count", 192'(fifo_count), 3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 192'(bus.m_valid), 0);
        chk("rst_async_count", 192'(fifo_count), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_valid", 192'(bus.m_valid), 0);
        chk("rst_data", 192'(bus.m_metadata), 0);
        chk("rst_count", 192'(fifo_count), 0);
        chk("rst_full", 192'(fifo_full), 0);
        seen = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.m_valid) seen = 1'b1;
            step();
        end
        chk("rst_no_stale", 192'(seen), 0);
        bus.m_ready = 1'b0;

        // saturation: 4 fills then 65537 drops
        bus.metadata = mk(12'h3);
        bus.metadata_valid = 1'b1;
        for (int i = 0; i < 4 + 65537; i++) step();
        chk("sat_count", 192'(fifo_count), 4);
        chk("sat_drops", 192'(drop_count), STATS ? 192'h0FFFF : 192'h0);
        chk("sat_ovf", 192'(overflow), 192'(STATS));
        drop_clr = 1'b1;
        step();
        chk("clr_drop_drops", 192'(drop_count), 192'(STATS));
        chk("clr_drop_ovf", 192'(overflow), 192'(STATS));
        bus.metadata_valid = 1'b0;
        step();
        chk("clr_drops", 192'(drop_count), 0);
        chk("clr_ovf", 192'(overflow), 0);
        drop_clr = 1'b0;
        held = bus.m_metadata;
        chk("sat_head", 192'(held), 192'(mk(12'h3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
